// File: rtl/ps2_host_rx_pkg.sv
// rtl/ps2_host_rx_pkg.sv - shared PS/2 host frame definitions
package ps2_host_rx_pkg;

    localparam int PS2_FRAME_BITS = 11;
    localparam int PS2_DATA_BITS  = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } ps2_state_t;

    // Odd parity: the data bits plus the parity bit must hold an odd number of ones.
    function automatic logic odd_parity_ok(input logic [PS2_DATA_BITS-1:0] data, input logic par);
        return ^{data, par};
    endfunction

endpackage

// File: rtl/ps2_rx_fifo.sv
// rtl/ps2_rx_fifo.sv - first-word fall-through byte FIFO for received scan codes
module ps2_rx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             pop_fire;
    logic             push_fire;

    assign full      = (count == (AW+1)'(DEPTH));
    assign empty     = (count == '0);
    assign pop_fire  = pop & ~empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO is still taken.
    assign push_fire = push & (~full | pop_fire);
    assign head      = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_fire) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop_fire) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_fire, pop_fire})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ps2_host_rx.sv
// rtl/ps2_host_rx.sv - PS/2 keyboard receiver with input filtering, frame checks and inhibit
module ps2_host_rx #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 20000,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic       bus_clk,
    input  logic       bus_reset_n,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    output logic       ps2_clk_oe,
    output logic       rd_valid,
    output logic [7:0] rd_data,
    input  logic       rd_ready,
    output logic       err_parity,
    output logic       err_frame,
    output logic       overflow
);

    import ps2_host_rx_pkg::*;

    localparam int FCW = $clog2(FILTER_LEN + 1);
    localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int MCW = $clog2(FILTER_LEN + 3);
    localparam int AW  = $clog2(FIFO_DEPTH);

    localparam logic [FCW-1:0] FLT_LAST = FCW'(FILTER_LEN - 1);
    localparam logic [TCW-1:0] TMO_LAST = TCW'(TIMEOUT_CYCLES - 1);
    localparam logic [MCW-1:0] MASK_LEN = MCW'(FILTER_LEN + 2);
    localparam logic [AW:0]    ALMOST   = (AW+1)'(FIFO_DEPTH - 1);
    localparam logic [2:0]     LAST_BIT = 3'(PS2_DATA_BITS - 1);

    logic [1:0]     clk_sync, data_sync;
    logic [FCW-1:0] clk_fcnt, data_fcnt;
    logic           flt_clk, flt_data, flt_clk_d;
    logic [MCW-1:0] mask_cnt;
    logic           masked, fall, strobe;

    ps2_state_t     state, state_next;
    logic [2:0]     bit_cnt;
    logic [7:0]     shreg;
    logic           par_q;
    logic [TCW-1:0] tmo_cnt;
    logic           start_en, shift_en, par_en, stop_en, tmo_hit;

    logic           good_q, err_parity_q, err_frame_q, oe_q;
    logic [7:0]     good_byte;
    logic           fifo_full, fifo_empty, pop_fire, will_be_full;
    logic [AW:0]    fifo_count;

    // Synchronizers and saturating glitch filters; idle bus level is high.
    always_ff @(posedge bus_clk or negedge bus_reset_n) begin
        if (!bus_reset_n) begin
            clk_sync  <= 2'b11;
            data_sync <= 2'b11;
            clk_fcnt  <= '0;
            data_fcnt <= '0;
            flt_clk   <= 1'b1;
            flt_data  <= 1'b1;
            flt_clk_d <= 1'b1;
        end else begin
            clk_sync  <= {clk_sync[0], ps2_clk_i};
            data_sync <= {data_sync[0], ps2_data_i};
            flt_clk_d <= flt_clk;
            if (clk_sync[1] == flt_clk) begin
                clk_fcnt <= '0;
            end else if (clk_fcnt == FLT_LAST) begin
                flt_clk  <= clk_sync[1];
                clk_fcnt <= '0;
            end else begin
                clk_fcnt <= clk_fcnt + 1'b1;
            end
            if (data_sync[1] == flt_data) begin
                data_fcnt <= '0;
            end else if (data_fcnt == FLT_LAST) begin
                flt_data  <= data_sync[1];
                data_fcnt <= '0;
            end else begin
                data_fcnt <= data_fcnt + 1'b1;
            end
        end
    end

    // Edges we cause ourselves by inhibiting, plus the filter settling tail, are never decoded.
    always_ff @(posedge bus_clk or negedge bus_reset_n) begin
        if (!bus_reset_n) begin
            mask_cnt <= '0;
        end else if (oe_q) begin
            mask_cnt <= MASK_LEN;
        end else if (mask_cnt != '0) begin
            mask_cnt <= mask_cnt - 1'b1;
        end
    end

    assign masked = oe_q | (mask_cnt != '0);
    assign fall   = flt_clk_d & ~flt_clk;
    assign strobe = fall & ~masked;

    always_ff @(posedge bus_clk or negedge bus_reset_n) begin
        if (!bus_reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (masked) begin
            state_next = IDLE;
        end else begin
            unique case (state)
                IDLE:    if (strobe && !flt_data) state_next = DATA;
                DATA:    if (strobe && bit_cnt == LAST_BIT) state_next = PARITY;
                         else if (tmo_hit) state_next = IDLE;
                PARITY:  if (strobe) state_next = STOP;
                         else if (tmo_hit) state_next = IDLE;
                STOP:    if (strobe || tmo_hit) state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    always_comb begin
        start_en = strobe && (state == IDLE) && !flt_data;
        shift_en = strobe && (state == DATA);
        par_en   = strobe && (state == PARITY);
        stop_en  = strobe && (state == STOP);
        tmo_hit  = (state != IDLE) && !strobe && (tmo_cnt == TMO_LAST);
    end

    always_ff @(posedge bus_clk or negedge bus_reset_n) begin
        if (!bus_reset_n) begin
            bit_cnt      <= '0;
            shreg        <= '0;
            par_q        <= 1'b0;
            tmo_cnt      <= '0;
            good_q       <= 1'b0;
            good_byte    <= '0;
            err_parity_q <= 1'b0;
            err_frame_q  <= 1'b0;
            oe_q         <= 1'b0;
        end else begin
            if (start_en) begin
                bit_cnt <= '0;
            end else if (shift_en) begin
                shreg[bit_cnt] <= flt_data;
                bit_cnt        <= bit_cnt + 1'b1;
            end
            if (par_en) begin
                par_q <= flt_data;
            end
            if (state == IDLE || strobe) begin
                tmo_cnt <= '0;
            end else begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end
            // Stop-bit error takes priority over parity; overflow is resolved against the FIFO next cycle.
            err_frame_q  <= tmo_hit | (stop_en & ~flt_data);
            err_parity_q <= stop_en & flt_data & ~odd_parity_ok(shreg, par_q);
            good_q       <= stop_en & flt_data & odd_parity_ok(shreg, par_q);
            if (stop_en) begin
                good_byte <= shreg;
            end
            oe_q <= will_be_full & (oe_q | (state == IDLE));
        end
    end

    assign pop_fire     = ~fifo_empty & rd_ready;
    assign will_be_full = (fifo_full & ~(pop_fire & ~good_q))
                        | ((fifo_count == ALMOST) & good_q & ~pop_fire);

    ps2_rx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk       (bus_clk),
        .rst_n     (bus_reset_n),
        .push      (good_q),
        .push_data (good_byte),
        .pop       (rd_ready),
        .head      (rd_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign ps2_clk_oe = oe_q;
    assign rd_valid   = ~fifo_empty;
    assign err_parity = err_parity_q;
    assign err_frame  = err_frame_q;
    assign overflow   = good_q & fifo_full & ~pop_fire;

endmodule

// File: tb/tb_ps2_host_rx.sv
// tb/tb_ps2_host_rx.sv - scoreboard bench for the PS/2 host receiver
`timescale 1ns/1ps
module tb_ps2_host_rx;

    localparam int FILTER_LEN     = 8;
    localparam int TIMEOUT_CYCLES = 20000;
    localparam int FIFO_DEPTH     = 4;
    localparam int CLK_NS         = 1000;
    localparam int QTR_NS         = 20000;

    logic       bus_clk     = 1'b0;
    logic       bus_reset_n = 1'b0;
    logic       kbd_clk     = 1'b1;
    logic       kbd_data    = 1'b1;
    logic       rd_ready    = 1'b0;
    logic       ps2_clk_pin;
    logic       ps2_clk_oe;
    logic       rd_valid;
    logic [7:0] rd_data;
    logic       err_parity;
    logic       err_frame;
    logic       overflow;

    int         n_checks = 0;
    int         n_errors = 0;
    int         n_par = 0;
    int         n_frm = 0;
    int         n_ovf = 0;
    time        t_fall = 0;
    logic [7:0] exp_q [$];

    assign ps2_clk_pin = kbd_clk & ~ps2_clk_oe;

    ps2_host_rx #(
        .FILTER_LEN     (FILTER_LEN),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .FIFO_DEPTH     (FIFO_DEPTH)
    ) dut (
        .bus_clk     (bus_clk),
        .bus_reset_n (bus_reset_n),
        .ps2_clk_i   (ps2_clk_pin),
        .ps2_data_i  (kbd_data),
        .ps2_clk_oe  (ps2_clk_oe),
        .rd_valid    (rd_valid),
        .rd_data     (rd_data),
        .rd_ready    (rd_ready),
        .err_parity  (err_parity),
        .err_frame   (err_frame),
        .overflow    (overflow)
    );

    always #(CLK_NS/2) bus_clk = ~bus_clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(negedge bus_clk) begin
        if (bus_reset_n) begin
            if (err_parity) n_par++;
            if (err_frame)  n_frm++;
            if (overflow)   n_ovf++;
            if (rd_valid && rd_ready) begin
                check_eq("sb_pending", 32'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) check_eq("rd_data", rd_data, exp_q.pop_front());
            end
        end
    end

    task automatic send_bit(input logic b, input bit glitch);
        kbd_data = b;
        #(QTR_NS/2);
        if (glitch) begin
            kbd_clk = 1'b0; #(3*CLK_NS); kbd_clk = 1'b1; #(QTR_NS/2 - 3*CLK_NS);
        end else begin
            #(QTR_NS/2);
        end
        kbd_clk = 1'b0;
        t_fall  = $time;
        #(QTR_NS);
        if (glitch) begin
            kbd_clk = 1'b1; #(3*CLK_NS); kbd_clk = 1'b0; #(QTR_NS - 3*CLK_NS);
        end else begin
            #(QTR_NS);
        end
        kbd_clk = 1'b1;
        #(QTR_NS);
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par, input logic stop,
                              input bit glitch, input int nbits);
        logic [10:0] f;
        f = {stop, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) send_bit(f[i], glitch);
        kbd_data = 1'b1;
    endtask

    task automatic wait_drain(input string tag);
        for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(negedge bus_clk);
        check_eq(tag, exp_q.size(), 0);
    endtask

    initial begin
        #(80_000_000);
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int found;
        int delta;

        repeat (3) @(posedge bus_clk);
        #1;
        check_eq("reset_outs", {rd_valid, rd_data, ps2_clk_oe, err_parity, err_frame, overflow}, 0);
        @(negedge bus_clk);
        bus_reset_n = 1'b1;
        rd_ready    = 1'b1;
        repeat (20) @(negedge bus_clk);

        // good frame 0x1C
        exp_q.push_back(8'h1C);
        send_frame(8'h1C, 0, 1'b1, 0, 11);
        wait_drain("t1_drain");
        check_eq("t1_errs", n_par + n_frm + n_ovf, 0);

        // parity error
        base = n_par;
        send_frame(8'h1C, 1, 1'b1, 0, 11);
        repeat (20) @(negedge bus_clk);
        check_eq("t2_par", n_par - base, 1);
        check_eq("t2_valid", rd_valid, 0);

        // bad stop bit
        base = n_frm;
        send_frame(8'hF0, 0, 1'b0, 0, 11);
        repeat (20) @(negedge bus_clk);
        check_eq("t3_frm", n_frm - base, 1);
        check_eq("t3_valid", rd_valid, 0);

        // timeout after start + 4 data bits
        base  = n_frm;
        found = 0;
        send_frame(8'h0A, 0, 1'b1, 0, 5);
        for (int i = 0; i < TIMEOUT_CYCLES + 1000; i++) begin
            @(negedge bus_clk);
            if (err_frame) begin
                found = 1;
                break;
            end
        end
        delta = int'(($time - t_fall) / CLK_NS);
        check_eq("t4_seen", found, 1);
        check_eq("t4_window", 32'(delta >= TIMEOUT_CYCLES && delta <= TIMEOUT_CYCLES + FILTER_LEN + 8), 1);
        repeat (5) @(negedge bus_clk);
        check_eq("t4_frm", n_frm - base, 1);
        exp_q.push_back(8'h5A);
        send_frame(8'h5A, 0, 1'b1, 0, 11);
        wait_drain("t4_drain");

        // fill FIFO, inhibit, extra frame, pop, refill
        rd_ready = 1'b0;
        for (int b = 1; b <= 4; b++) begin
            exp_q.push_back(8'(b));
            send_frame(8'(b), 0, 1'b1, 0, 11);
        end
        repeat (10) @(negedge bus_clk);
        check_eq("t5_oe_full", ps2_clk_oe, 1);
        check_eq("t5_head", {rd_valid, rd_data}, {1'b1, 8'h01});
        send_frame(8'h99, 0, 1'b1, 0, 11);
        repeat (20) @(negedge bus_clk);
        check_eq("t5_head_kept", rd_data, 8'h01);
        check_eq("t5_oe_hold", ps2_clk_oe, 1);
        @(posedge bus_clk); #1 rd_ready = 1'b1;
        @(posedge bus_clk); #1 rd_ready = 1'b0;
        @(negedge bus_clk);
        check_eq("t5_oe_release", ps2_clk_oe, 0);
        check_eq("t5_head2", rd_data, 8'h02);
        repeat (40) @(negedge bus_clk);
        exp_q.push_back(8'h05);
        send_frame(8'h05, 0, 1'b1, 0, 11);
        repeat (10) @(negedge bus_clk);
        check_eq("t5_oe_refull", ps2_clk_oe, 1);
        rd_ready = 1'b1;
        wait_drain("t5_drain");
        repeat (40) @(negedge bus_clk);
        check_eq("t5_oe_empty", ps2_clk_oe, 0);

        // glitches on the clock pin
        base = n_par + n_frm;
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, 0, 1'b1, 1, 11);
        wait_drain("t6_drain");
        check_eq("t6_errs", n_par + n_frm - base, 0);

        // reset mid-frame with a byte queued
        rd_ready = 1'b0;
        exp_q.push_back(8'h3C);
        send_frame(8'h3C, 0, 1'b1, 0, 11);
        repeat (20) @(negedge bus_clk);
        check_eq("t7_pre", {rd_valid, rd_data}, {1'b1, 8'h3C});
        send_frame(8'h77, 0, 1'b1, 0, 5);
        #(CLK_NS/4);
        bus_reset_n = 1'b0;
        #1;
        check_eq("t7_reset_outs", {rd_valid, rd_data, ps2_clk_oe, err_parity, err_frame, overflow}, 0);
        exp_q.delete();
        repeat (3) @(negedge bus_clk);
        bus_reset_n = 1'b1;
        rd_ready    = 1'b1;
        repeat (20) @(negedge bus_clk);
        exp_q.push_back(8'h7E);
        send_frame(8'h7E, 0, 1'b1, 0, 11);
        wait_drain("t7_drain");

        repeat (10) @(negedge bus_clk);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
